mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency unified memory between the fetch

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (read-only)
// and data (read/write) ports; one access in flight, data port favoured with fetch anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3,
    localparam int LAT_W       = $clog2(MEM_LATENCY + 1),
    localparam int STV_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state,
    output logic [STV_W-1:0]  dbg_starve_cnt
);

    // Handshake: a requester raises req with its operands and holds them
    // until the one-cycle ready pulse; ready means rdata is valid that cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic                dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_dm    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    // Fetch is forced through once it has lost STARVE_LIMIT times in a row.
                    grant_dm    = dm_req && (!if_req || (starve_q < STV_W'(STARVE_LIMIT)));
                    owner_d     = grant_dm ? OWN_DM : OWN_IF;
                    we_d        = grant_dm && dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dm && dm_we;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                    lat_d       = LAT_W'(MEM_LATENCY);
                    if (grant_dm && if_req) begin
                        starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q
                                                                      : starve_q + STV_W'(1);
                    end else if (!grant_dm) begin
                        starve_d = '0;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = we_q ? '0 : mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_ready       = if_ready_q;
    assign dm_ready       = dm_ready_q;
    assign if_rdata       = if_rdata_q;
    assign dm_rdata       = dm_rdata_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign stall_f        = if_req & ~if_ready_q;
    assign stall_m        = dm_req & ~dm_ready_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_q;

endmodule
